// File: rtl/vga_text_render.sv
// vga_text_render: character-cell text renderer with 4x-scaled 8x12 glyphs and a blinking block cursor
module vga_text_render #(
  parameter int COLS = 10,
  parameter int ROWS = 3,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [5:0]    x_hi,
  input  logic [4:0]    x_lo,
  input  logic [4:0]    y_hi,
  input  logic [5:0]    y_lo,
  input  logic          blank,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [6:0]    wr_data,
  input  logic [5:0]    fg_color,
  input  logic [5:0]    bg_color,
  input  logic          cursor_en,
  input  logic [AW-1:0] cursor_pos,
  output logic [6:0]    font_char,
  output logic [3:0]    font_row,
  input  logic [7:0]    font_bits,
  output logic [5:0]    rgb,
  output logic          hsync_out,
  output logic          vsync_out
);
  localparam int N = COLS * ROWS;
  localparam logic [6:0] SPACE = 7'h20;
  logic [6:0]  mem [2**AW];
  logic [10:0] idx;
  logic        in_range, inr1, cur1, blank1, hs1, vs1, vsync_prev, pix2;
  logic [6:0]  char1;
  logic [2:0]  gx1;
  logic [3:0]  gy1;
  logic [4:0]  frame_cnt;
  assign idx       = 11'(y_hi) * 11'(COLS) + 11'(x_hi);
  assign in_range  = (int'(x_hi) < COLS) && (int'(y_hi) < ROWS) && !blank;
  assign font_char = char1;
  assign font_row  = gy1;
  assign pix2      = (inr1 & font_bits[3'd7 - gx1]) ^ (cur1 & frame_cnt[4]);
  // character buffer: cleared to spaces on reset, out-of-range writes dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**AW; i++) mem[i] <= SPACE;
    else if (wr_en && int'(wr_addr) < N)
      mem[wr_addr] <= wr_data;
  // stage 1: cell lookup, cursor match and glyph coordinates
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inr1   <= 1'b0;
      char1  <= '0;
      cur1   <= 1'b0;
      gx1    <= '0;
      gy1    <= '0;
      blank1 <= 1'b0;
      hs1    <= 1'b0;
      vs1    <= 1'b0;
    end else begin
      inr1   <= in_range;
      char1  <= in_range ? mem[idx[AW-1:0]] : SPACE;
      cur1   <= cursor_en && in_range && (idx == 11'(cursor_pos));
      gx1    <= x_lo[4:2];
      gy1    <= y_lo[5:2];
      blank1 <= blank;
      hs1    <= hsync;
      vs1    <= vsync;
    end
  // stage 2: glyph bit select, cursor inversion and colour mux
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rgb       <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      rgb       <= blank1 ? 6'd0 : (pix2 ? fg_color : bg_color);
      hsync_out <= hs1;
      vsync_out <= vs1;
    end
  // blink counter: one step per vsync rising edge, bit 4 toggles every 16 frames
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vsync_prev <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      vsync_prev <= vsync;
      if (vsync && !vsync_prev) frame_cnt <= frame_cnt + 5'd1;
    end
endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: directed table-driven bench for vga_text_render
module tb_vga_text_render;
  logic       clk = 0, rst_n = 0;
  logic [5:0] x_hi = 0;
  logic [4:0] x_lo = 0;
  logic [4:0] y_hi = 0;
  logic [5:0] y_lo = 0;
  logic       blank = 0, hsync = 0, vsync = 0, wr_en = 0, cursor_en = 0;
  logic [4:0] wr_addr = 0, cursor_pos = 0;
  logic [6:0] wr_data = 0;
  logic [5:0] fg_color = 6'h2A, bg_color = 6'h15;
  logic [6:0] font_char;
  logic [3:0] font_row;
  logic [7:0] font_bits;
  logic [5:0] rgb;
  logic       hsync_out, vsync_out;
  int tests = 0, fails = 0;
  localparam logic [5:0] FG = 6'h2A, BG = 6'h15;

  vga_text_render dut (
    .clk(clk), .rst_n(rst_n), .x_hi(x_hi), .x_lo(x_lo), .y_hi(y_hi), .y_lo(y_lo),
    .blank(blank), .hsync(hsync), .vsync(vsync), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .fg_color(fg_color), .bg_color(bg_color), .cursor_en(cursor_en),
    .cursor_pos(cursor_pos), .font_char(font_char), .font_row(font_row),
    .font_bits(font_bits), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // font ROM model: 0x41 row 0 = leftmost pixel, 0x58 row 0 = full row, all else blank
  always_comb
    font_bits = (font_char == 7'h41 && font_row == 4'd0) ? 8'h80 :
                (font_char == 7'h58 && font_row == 4'd0) ? 8'hFF : 8'h00;

  // frame counter reference used only to align the blink phase
  logic [4:0] fc_model;
  logic       vp_model;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fc_model <= 0;
      vp_model <= 0;
    end else begin
      vp_model <= vsync;
      if (vsync && !vp_model) fc_model <= fc_model + 5'd1;
    end

  typedef struct {
    logic [5:0] xh; logic [4:0] xl; logic [4:0] yh; logic [5:0] yl; logic bl;
    logic [6:0] fc; logic [3:0] fr; logic [5:0] rgb;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [6:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    step(1);
    wr_en = 0;
  endtask

  task automatic pix(input logic [5:0] xh, input logic [4:0] xl, input logic [4:0] yh,
                     input logic [5:0] yl, input logic bl);
    x_hi = xh; x_lo = xl; y_hi = yh; y_lo = yl; blank = bl;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      vsync = 1; step(1);
      vsync = 0; step(1);
    end
  endtask

  logic [11:0] hpat, vpat, bpat;
  logic        hh[12], vh[12], bh[12];
  int          guard;

  initial begin
    vecs[0]  = '{6'd2,  5'd0,  5'd1, 6'd0,  1'b0, 7'h41, 4'd0,  FG};
    vecs[1]  = '{6'd2,  5'd3,  5'd1, 6'd3,  1'b0, 7'h41, 4'd0,  FG};
    vecs[2]  = '{6'd2,  5'd4,  5'd1, 6'd0,  1'b0, 7'h41, 4'd0,  BG};
    vecs[3]  = '{6'd2,  5'd31, 5'd1, 6'd0,  1'b0, 7'h41, 4'd0,  BG};
    vecs[4]  = '{6'd2,  5'd0,  5'd1, 6'd4,  1'b0, 7'h41, 4'd1,  BG};
    vecs[5]  = '{6'd2,  5'd0,  5'd1, 6'd0,  1'b1, 7'h20, 4'd0,  6'h00};
    vecs[6]  = '{6'd0,  5'd0,  5'd0, 6'd0,  1'b0, 7'h20, 4'd0,  BG};
    vecs[7]  = '{6'd12, 5'd0,  5'd0, 6'd0,  1'b0, 7'h20, 4'd0,  BG};
    vecs[8]  = '{6'd10, 5'd0,  5'd1, 6'd0,  1'b0, 7'h20, 4'd0,  BG};
    vecs[9]  = '{6'd2,  5'd0,  5'd3, 6'd0,  1'b0, 7'h20, 4'd0,  BG};
    vecs[10] = '{6'd9,  5'd31, 5'd2, 6'd47, 1'b0, 7'h20, 4'd11, BG};

    #2;
    chk("reset_rgb", rgb, 0);
    chk("reset_hs", hsync_out, 0);
    chk("reset_vs", vsync_out, 0);
    chk("reset_fc", font_char, 0);
    #20 rst_n = 1;
    step(1);

    hpat = 12'b101100111010; vpat = 12'b000110000110; bpat = 12'b110001010011;
    for (int i = 0; i < 12; i++) begin
      hh[i] = hpat[i]; vh[i] = vpat[i]; bh[i] = bpat[i];
      hsync = hh[i]; vsync = vh[i];
      pix(6'(i), 5'd0, 5'd0, 6'd0, bh[i]);
      step(1);
      if (i >= 1) begin
        chk("idle_hs", hsync_out, hh[i-1]);
        chk("idle_vs", vsync_out, vh[i-1]);
        chk("idle_rgb", rgb, bh[i-1] ? 6'd0 : BG);
      end
    end
    hsync = 0; vsync = 0;

    wr(5'd12, 7'h41);
    for (int i = 0; i < 11; i++) begin
      pix(vecs[i].xh, vecs[i].xl, vecs[i].yh, vecs[i].yl, vecs[i].bl);
      step(1);
      chk($sformatf("vec%0d_char", i), font_char, vecs[i].fc);
      chk($sformatf("vec%0d_row", i), font_row, vecs[i].fr);
      step(1);
      chk($sformatf("vec%0d_rgb", i), rgb, vecs[i].rgb);
    end

    pix(6'd0, 5'd0, 5'd0, 6'd0, 1'b0);
    step(2);
    wr_en = 1; wr_addr = 0; wr_data = 7'h58;
    step(1);
    wr_en = 0;
    chk("same_old_char", font_char, 7'h20);
    step(1);
    chk("same_new_char", font_char, 7'h58);
    chk("same_old_rgb", rgb, BG);
    step(1);
    chk("same_new_rgb", rgb, FG);

    wr(5'd30, 7'h41);
    wr(5'd31, 7'h41);
    step(1);
    chk("oor_wr_cell0", font_char, 7'h58);
    pix(6'd2, 5'd0, 5'd1, 6'd0, 1'b0);
    step(1);
    chk("oor_wr_cell12", font_char, 7'h41);

    cursor_en = 1; cursor_pos = 0;
    pix(6'd0, 5'd0, 5'd0, 6'd4, 1'b0);
    guard = 0;
    while (fc_model != 0 && guard < 40) begin
      pulse(1);
      guard++;
    end
    chk("blink_align", guard < 40, 1);
    step(2);
    chk("cur_off0", rgb, BG);
    pulse(16); step(2);
    chk("cur_on16", rgb, FG);
    cursor_en = 0; step(2);
    chk("cur_dis", rgb, BG);
    cursor_en = 1; cursor_pos = 12;
    pix(6'd12, 5'd0, 5'd0, 6'd4, 1'b0); step(2);
    chk("cur_oor_col", rgb, BG);
    pix(6'd2, 5'd0, 5'd1, 6'd4, 1'b0); step(2);
    chk("cur_pos12", rgb, FG);
    pix(6'd2, 5'd0, 5'd3, 6'd4, 1'b0); cursor_pos = 0; step(2);
    chk("cur_oor_row", rgb, BG);
    pix(6'd0, 5'd0, 5'd0, 6'd4, 1'b1); step(2);
    chk("cur_blank", rgb, 0);
    pix(6'd0, 5'd0, 5'd0, 6'd4, 1'b0);
    pulse(15); step(2);
    chk("cur_on31", rgb, FG);
    pulse(1); step(2);
    chk("cur_wrap", rgb, BG);
    cursor_en = 0;

    pix(6'd2, 5'd0, 5'd1, 6'd0, 1'b0);
    hsync = 1; vsync = 1;
    step(2);
    chk("pre_rst_rgb", rgb, FG);
    chk("pre_rst_hs", hsync_out, 1);
    #3 rst_n = 0;
    #1;
    chk("rst_async_rgb", rgb, 0);
    chk("rst_async_hs", hsync_out, 0);
    chk("rst_async_vs", vsync_out, 0);
    #10 rst_n = 1;
    step(1);
    chk("post_rst_char", font_char, 7'h20);
    step(1);
    chk("post_rst_rgb", rgb, BG);
    chk("post_rst_hs", hsync_out, 1);
    chk("post_rst_vs", vsync_out, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Pixel stage directly downstream of the VGA timing generator in the console.
- Consumes the 32x48-pixel cell coordinates (x_hi/x_lo, y_hi/y_lo), blank, hsync and vsync.
- Holds a small character buffer and looks glyphs up in an external combinational 8x12 font ROM, scaled 4x to fill the cell.
- Emits RGB222 pixels plus hsync/vsync delayed to match, with a blinking block cursor.

Parameters:
- COLS, 10, text columns shown from cell column 0; cell columns COLS..31 render background.
- ROWS, 3, text rows shown from cell row 0; cell rows ROWS..15 render background.
- AW, 5, width of wr_addr and cursor_pos; must satisfy 2^AW >= COLS*ROWS.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- x_hi  in  6  cell column from timing
- x_lo  in  5  pixel within cell column, 0..31
- y_hi  in  5  cell row from timing
- y_lo  in  6  line within cell row, 0..47
- blank  in  1  outside visible area
- hsync  in  1  horizontal sync from timing, active-low
- vsync  in  1  vertical sync from timing, active-high
- wr_en  in  1  character write strobe
- wr_addr  in  AW  character index = row*COLS+col
- wr_data  in  7  character code
- fg_color  in  6  foreground RGB222
- bg_color  in  6  background RGB222
- cursor_en  in  1  enable cursor
- cursor_pos  in  AW  cursor character index
- font_char  out  7  glyph select to font ROM (comb. from stage-1 regs)
- font_row  out  4  glyph row 0..11 to font ROM
- font_bits  in  8  glyph row bits, MSB = leftmost pixel, valid same cycle
- rgb  out  6  pixel colour {R1,R0,G1,G0,B1,B0}
- hsync_out  out  1  hsync delayed 2 cycles
- vsync_out  out  1  vsync delayed 2 cycles

Behaviour:
- Reset, asynchronous:
  - Buffer cleared to 0x20 (space) in every entry.
  - rgb=0, hsync_out=0, vsync_out=0.
  - All pipeline registers 0; frame_cnt=0; vsync_prev=0.
  - Reset mid-frame takes effect immediately. Output is valid 2 cycles after release.
- Buffer write: on a clk edge with wr_en=1 and wr_addr<COLS*ROWS, entry wr_addr <= wr_data. wr_addr>=COLS*ROWS is ignored.
- Buffer read: combinational, using the pre-edge contents. If a write and a read hit the same cell in the same cycle, the old value is displayed and the new value appears from the next cycle.
- Stage 1 (edge after inputs):
  - inr1 <= (x_hi<COLS)&(y_hi<ROWS)&!blank.
  - char1 <= inr1-condition ? buf[y_hi*COLS+x_hi] : 0x20.
  - cur1 <= cursor_en & inr1-condition & (y_hi*COLS+x_hi == cursor_pos).
  - gx1 <= x_lo[4:2]; gy1 <= y_lo[5:2].
  - blank1, hs1, vs1 <= inputs.
- Font interface: font_char=char1 and font_row=gy1, both combinational.
- Stage 2:
  - pix = inr1 & font_bits[7-gx1].
  - pix2 = pix XOR (cur1 & frame_cnt[4]).
  - rgb <= blank1 ? 0 : (pix2 ? fg_color : bg_color).
  - hsync_out <= hs1; vsync_out <= vs1.
- Latency: exactly 2 clk from timing inputs to rgb/hsync_out/vsync_out, fixed, no stalls.
- Blink:
  - vsync_prev <= vsync every cycle.
  - On vsync & !vsync_prev, frame_cnt (5 bits) increments, wrapping 31->0.
  - Cursor is inverted while frame_cnt[4]=1, i.e. 16 frames on and 16 off.
- fg_color, bg_color and cursor inputs are sampled live. A change mid-line takes effect 1–2 cycles later with no glitch filtering.
- Out-of-range cells, rows beyond ROWS, and blank regions never show cursor or glyph pixels.

Test Plan:
- Reset then idle frame, all buffer entries 0x20, font model returns 0 for 0x20 -> rgb==bg_color for every visible pixel, rgb==0 in blank. hsync_out/vsync_out equal the inputs delayed exactly 2 cycles.
- Write 0x41 at wr_addr 12 (row 1, col 2); font model returns 8'h80 for row 0 of 0x41. Drive x_hi=2, x_lo=0..3, y_hi=1, y_lo=0..3 -> rgb==fg_color 2 cycles later. x_lo=4 -> bg_color. font_char==0x41 and font_row==0 one cycle after the inputs.
- Same-cycle write and read of cell 0 (old 0x20, new 0x58) -> first pixel renders glyph 0x20; the following cycle presents font_char 0x58.
- cursor_en=1, cursor_pos=0, 16 vsync rising edges -> cell 0 background pixels read fg_color. After 16 more edges -> bg_color. frame_cnt wraps after 32 edges.
- Cells x_hi=COLS (10) and y_hi=ROWS (3); wr_addr=30 (>=COLS*ROWS) -> rgb==bg_color, cursor ignored, buffer unchanged.
- Assert rst_n low mid-line with buffer holding 0x41 -> rgb, hsync_out and vsync_out go 0 immediately without waiting for a clock. Buffer reads 0x20 after release.
